// File: rtl/mem_io_pkg.sv
// Shared types and default address map for the CPU memory/IO bridge:
// FSM state encoding, request decode classes and IO address constants.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_e;

  // Where an accepted request is steered; DC_BAD covers unmapped IO and
  // accesses in the wrong direction (store to input, load from output).
  typedef enum logic [1:0] {
    DC_MEM = 2'd0,
    DC_OUT = 2'd1,
    DC_IN  = 2'd2,
    DC_BAD = 2'd3
  } dec_cls_e;

  localparam logic [31:0] IO_BASE_DEF   = 32'hFFFF_FC00;
  localparam logic [31:0] IN_OFS_DEF    = 32'h0000_0200;
  localparam logic [31:0] CH_STRIDE_DEF = 32'h0000_0010;

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU request/response handshake plus data-memory port of the bridge.
// slave = bridge view, master = CPU/memory environment view.
interface mem_io_bridge_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              dmem_en;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, dmem_rdata,
    output busy, rsp_valid, rsp_rdata, rsp_err,
           dmem_en, dmem_we, dmem_addr, dmem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, dmem_rdata,
    input  busy, rsp_valid, rsp_rdata, rsp_err,
           dmem_en, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/io_sync2.sv
// Two-flop synchroniser for one asynchronous input channel (reset to 0).
module io_sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/mem_io_bridge.sv
// Steers CPU loads/stores to data memory or memory-mapped IO channels.
// Define MEMIO_RDBACK_EN to let loads read back the output channel registers.
module mem_io_bridge import mem_io_pkg::*; #(
  parameter int                DATA_W     = 32,
  parameter int                IO_W       = 24,
  parameter int                NUM_OUT_CH = 2,
  parameter int                NUM_IN_CH  = 2,
  parameter logic [DATA_W-1:0] IO_BASE    = DATA_W'(IO_BASE_DEF),
  parameter logic [DATA_W-1:0] IN_OFS     = DATA_W'(IN_OFS_DEF),
  parameter logic [DATA_W-1:0] CH_STRIDE  = DATA_W'(CH_STRIDE_DEF),
  parameter int                MEM_RD_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  mem_io_bridge_if.slave             bus,
  output logic [NUM_OUT_CH*IO_W-1:0] io_out,
  output logic [NUM_OUT_CH-1:0]      io_out_stb,
  input  logic [NUM_IN_CH*IO_W-1:0]  io_in
);

  localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

`ifdef MEMIO_RDBACK_EN
  localparam bit RDBACK = 1'b1;
`else
  localparam bit RDBACK = 1'b0;
`endif

  state_e                     state, state_n;
  dec_cls_e                   cls;
  logic                       is_io;
  logic [DATA_W-1:0]          io_off;
  logic [DATA_W-1:0]          in_off;
  logic [NUM_OUT_CH-1:0]      out_hit;
  logic [NUM_IN_CH-1:0]       in_hit;
  logic [IO_W-1:0]            out_rb;
  logic [IO_W-1:0]            in_rd;
  logic [NUM_IN_CH*IO_W-1:0]  io_in_sync;
  logic                       accept;
  logic                       dmem_en;
  logic                       dmem_we;
  logic [CNT_W-1:0]           cnt;
  logic                       cnt_last;
  logic [DATA_W-1:0]          rdata_q;
  logic                       err_q;
  logic [NUM_OUT_CH*IO_W-1:0] io_out_q;
  logic [NUM_OUT_CH-1:0]      stb_q;

  for (genvar g = 0; g < NUM_IN_CH; g++) begin : g_sync
    io_sync2 #(.W(IO_W)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (io_in[g*IO_W +: IO_W]),
      .q       (io_in_sync[g*IO_W +: IO_W])
    );
  end

  // Address decode works on offsets from IO_BASE so channel windows are
  // simple [k*stride, (k+1)*stride) ranges; output windows win any overlap.
  always_comb begin
    is_io   = (bus.req_addr >= IO_BASE);
    io_off  = bus.req_addr - IO_BASE;
    in_off  = io_off - IN_OFS;
    out_hit = '0;
    in_hit  = '0;
    out_rb  = '0;
    in_rd   = '0;
    for (int k = 0; k < NUM_OUT_CH; k++) begin
      if (is_io && io_off >= DATA_W'(k) * CH_STRIDE &&
          io_off < DATA_W'(k + 1) * CH_STRIDE) begin
        out_hit[k] = 1'b1;
        out_rb     = out_rb | io_out_q[k*IO_W +: IO_W];
      end
    end
    for (int k = 0; k < NUM_IN_CH; k++) begin
      if (is_io && out_hit == '0 && io_off >= IN_OFS &&
          in_off >= DATA_W'(k) * CH_STRIDE &&
          in_off < DATA_W'(k + 1) * CH_STRIDE) begin
        in_hit[k] = 1'b1;
        in_rd     = in_rd | io_in_sync[k*IO_W +: IO_W];
      end
    end
    cls = DC_BAD;
    if (!is_io) begin
      cls = DC_MEM;
    end else if (|out_hit) begin
      cls = (bus.req_write || RDBACK) ? DC_OUT : DC_BAD;
    end else if (|in_hit) begin
      cls = bus.req_write ? DC_BAD : DC_IN;
    end
  end

  assign accept   = (state == IDLE) && bus.req_valid;
  assign cnt_last = (cnt == CNT_W'(MEM_RD_LAT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    dmem_en = 1'b0;
    dmem_we = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cls == DC_MEM) begin
            dmem_en = 1'b1;
            dmem_we = bus.req_write;
            state_n = bus.req_write ? RESP : MEM_WAIT;
          end else begin
            state_n = RESP;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_last) begin
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Response data, IO side effects and the read-latency counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      io_out_q <= '0;
      stb_q    <= '0;
    end else begin
      stb_q <= '0;
      cnt   <= (state == MEM_WAIT) ? cnt + 1'b1 : '0;
      if (accept) begin
        err_q   <= (cls == DC_BAD);
        rdata_q <= '0;
        case (cls)
          DC_OUT: begin
            if (bus.req_write) begin
              for (int k = 0; k < NUM_OUT_CH; k++) begin
                if (out_hit[k]) begin
                  io_out_q[k*IO_W +: IO_W] <= bus.req_wdata[IO_W-1:0];
                end
              end
              stb_q <= out_hit;
            end else begin
              rdata_q <= DATA_W'(out_rb);
            end
          end
          DC_IN:   rdata_q <= DATA_W'(in_rd);
          default: ;
        endcase
      end
      if (state == MEM_WAIT && cnt_last) begin
        rdata_q <= bus.dmem_rdata;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_err    = (state == RESP) && err_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.dmem_en    = dmem_en;
  assign bus.dmem_we    = dmem_we;
  assign bus.dmem_addr  = dmem_en ? bus.req_addr : '0;
  assign bus.dmem_wdata = dmem_we ? bus.req_wdata : '0;
  assign io_out         = io_out_q;
  assign io_out_stb     = stb_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomised bench for mem_io_bridge against a transaction-level reference model.
module tb_mem_io_bridge;
  localparam int          DATA_W  = 32;
  localparam int          IO_W    = 24;
  localparam int          NOUT    = 2;
  localparam int          NIN     = 2;
  localparam int          LAT     = 3;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
  localparam logic [31:0] IN_OFS  = 32'h200;
  localparam logic [31:0] STRIDE  = 32'h10;
`ifdef MEMIO_RDBACK_EN
  localparam bit RDBACK = 1'b1;
`else
  localparam bit RDBACK = 1'b0;
`endif

  logic                 clock;
  logic                 reset_n;
  logic [NOUT*IO_W-1:0] io_out;
  logic [NOUT-1:0]      io_out_stb;
  logic [NIN*IO_W-1:0]  io_in;

  mem_io_bridge_if #(.DATA_W(DATA_W)) bus ();

  mem_io_bridge #(
    .DATA_W(DATA_W), .IO_W(IO_W), .NUM_OUT_CH(NOUT), .NUM_IN_CH(NIN),
    .IO_BASE(IO_BASE), .IN_OFS(IN_OFS), .CH_STRIDE(STRIDE), .MEM_RD_LAT(LAT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .io_out     (io_out),
    .io_out_stb (io_out_stb),
    .io_in      (io_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model state: one transaction in flight at a time.
  bit          chk_en = 0;
  bit          rnd_io = 0;
  bit          act = 0;
  int          acc_c = 0;
  int          rsp_c = 0;
  bit          exp_mem_en, exp_we, exp_err, chk_rdata;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [1:0]  exp_stb;
  logic [23:0] ref_out [NOUT];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  logic [47:0] h0 = '0;
  logic [47:0] h1 = '0;
  int          rd_due = -1;
  logic [31:0] rd_addr = '0;
  logic [31:0] last_rdata = '0;
  bit          last_err = 0;
  int          last_rsp_cyc = 0;
  logic [1:0]  last_stb = '0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  // Data memory device: stores on the access cycle, returns read data LAT
  // cycles later, junk otherwise.
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      h0 = '0;
      h1 = '0;
    end else begin
      h1 = h0;
      h0 = io_in;
    end
    if (bus.dmem_en) begin
      if (bus.dmem_we) dev_mem[bus.dmem_addr] = bus.dmem_wdata;
      else begin
        rd_due  = cyc + LAT;
        rd_addr = bus.dmem_addr;
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (cyc == rd_due)
      bus.dmem_rdata = dev_mem.exists(rd_addr) ? dev_mem[rd_addr] : mem_init(rd_addr);
    else
      bus.dmem_rdata = $urandom;
  end

  // Compare process: every cycle's outputs against the model.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      bit         e_busy, e_rv, e_den;
      logic [1:0] e_stb;
      e_busy = act && cyc > acc_c && cyc <= rsp_c;
      e_rv   = act && cyc == rsp_c;
      e_den  = act && cyc == acc_c && exp_mem_en;
      e_stb  = (act && cyc == acc_c + 1) ? exp_stb : 2'b00;
      check("busy", bus.busy, e_busy);
      check("rsp_valid", bus.rsp_valid, e_rv);
      check("io_out_stb", io_out_stb, e_stb);
      check("dmem_en", bus.dmem_en, e_den);
      check("io_out", io_out, {ref_out[1], ref_out[0]});
      if (e_den) begin
        check("dmem_we", bus.dmem_we, exp_we);
        check("dmem_addr", bus.dmem_addr, exp_addr);
        if (exp_we) check("dmem_wdata", bus.dmem_wdata, exp_wdata);
      end
      if (e_rv) begin
        check("rsp_err", bus.rsp_err, exp_err);
        if (chk_rdata) check("rsp_rdata", bus.rsp_rdata, exp_rdata);
      end
    end
    if (bus.rsp_valid) begin
      last_rdata   = bus.rsp_rdata;
      last_err     = bus.rsp_err;
      last_rsp_cyc = cyc;
    end
    if (|io_out_stb) last_stb = io_out_stb;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One CPU transaction; entered and left at 1 time unit after a rising edge.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d);
    int          lat;
    int          k;
    int          pk;
    bit          pend_out;
    logic [23:0] pv;
    logic [31:0] off;
    if (rnd_io && $urandom_range(0, 1) == 1) io_in = {24'($urandom), 24'($urandom)};
    exp_mem_en = 0; exp_we = w; exp_addr = a; exp_wdata = d;
    exp_stb = 2'b00; exp_err = 0; exp_rdata = '0; chk_rdata = !w;
    lat = 1; pend_out = 0; pk = 0; pv = '0;
    if (a < IO_BASE) begin
      exp_mem_en = 1;
      if (w) ref_mem[a] = d;
      else begin
        lat = LAT + 1;
        exp_rdata = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
      end
    end else begin
      off = a - IO_BASE;
      if (off < NOUT * STRIDE) begin
        k = int'(off / STRIDE);
        if (w) begin
          pend_out = 1; pk = k; pv = d[23:0];
          exp_stb = 2'(1 << k);
        end else if (RDBACK) exp_rdata = {8'h00, ref_out[k]};
        else exp_err = 1;
      end else if (off >= IN_OFS && off - IN_OFS < NIN * STRIDE) begin
        k = int'((off - IN_OFS) / STRIDE);
        if (w) exp_err = 1;
        else exp_rdata = {8'h00, h1[k*IO_W +: IO_W]};
      end else begin
        exp_err = 1;
      end
    end
    if (exp_err) chk_rdata = 1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    acc_c = cyc;
    rsp_c = cyc + lat;
    act   = 1;
    @(posedge clock);
    #1;
    if (pend_out) ref_out[pk] = pv;
    repeat (lat) begin
      @(posedge clock);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    act = 0;
  endtask

  task automatic rand_txn();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0, 1:    a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      2:       a = IO_BASE - 32'($urandom_range(1, 4));
      3:       a = IO_BASE + 32'($urandom_range(0, 3)) * STRIDE + 32'($urandom_range(0, 15));
      4:       a = IO_BASE + IN_OFS + 32'($urandom_range(0, 3)) * STRIDE + 32'($urandom_range(0, 15));
      5:       a = IO_BASE + 32'($urandom_range(0, 1023));
      default: a = $urandom;
    endcase
    txn(1'($urandom_range(0, 1)), a, $urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    io_in = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.dmem_rdata = '0;
    foreach (ref_out[i]) ref_out[i] = '0;
    idle(3);
    check("rst_busy_low", bus.busy, 1'b0);
    reset_n = 1'b1;
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_io_out", io_out, '0);
    check("rst_stb", io_out_stb, '0);
    check("rst_dmem_en", bus.dmem_en, 1'b0);
    chk_en = 1;
    idle(3);

    // Store to output channel 1.
    last_stb = '0;
    txn(1'b1, 32'hFFFF_FC10, 32'h1234_5678);
    check("lit_out1", io_out[47:24], 24'h345678);
    check("lit_model_out1", ref_out[1], 24'h345678);
    check("lit_stb", last_stb, 2'b10);
    check("lit_store_lat", 32'(last_rsp_cyc - acc_c), 32'd1);
    check("lit_store_err", last_err, 1'b0);

    // Memory store then load with LAT=3.
    txn(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    check("lit_model_mem", ref_mem[32'h40], 32'hDEAD_BEEF);
    txn(1'b0, 32'h0000_0040, 32'h0);
    check("lit_mem_rdata", last_rdata, 32'hDEAD_BEEF);
    check("lit_mem_lat", 32'(last_rsp_cyc - acc_c), 32'd4);

    // Synchronised input channel 0.
    io_in = {24'h000000, 24'hABCDEF};
    idle(3);
    txn(1'b0, 32'hFFFF_FE00, 32'h0);
    check("lit_in0", last_rdata, 32'h00AB_CDEF);

    // Unmapped output channel.
    last_stb = '0;
    txn(1'b0, 32'hFFFF_FC40, 32'h0);
    check("lit_bad_rdata", last_rdata, 32'h0);
    check("lit_bad_err", last_err, 1'b1);
    check("lit_bad_stb", last_stb, 2'b00);

    // Output channel 0 readback.
    txn(1'b1, 32'hFFFF_FC00, 32'h55);
    txn(1'b0, 32'hFFFF_FC00, 32'h0);
`ifdef MEMIO_RDBACK_EN
    check("lit_rdback_rdata", last_rdata, 32'h55);
    check("lit_rdback_err", last_err, 1'b0);
`else
    check("lit_rdback_rdata", last_rdata, 32'h0);
    check("lit_rdback_err", last_err, 1'b1);
`endif

    rnd_io = 1;
    for (int i = 0; i < 300; i++) begin
      rand_txn();
      idle($urandom_range(0, 2));
    end
    rnd_io = 0;

    // Reset in the middle of a memory read.
    txn(1'b1, IO_BASE, 32'h00A5_A5A5);
    chk_en = 0;
    bus.req_write = 1'b0; bus.req_addr = 32'h100; bus.req_valid = 1'b1;
    idle(2);
    check("pre_rst_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_io_out", io_out, '0);
    check("mid_rst_stb", io_out_stb, '0);
    bus.req_valid = 1'b0;
    foreach (ref_out[i]) ref_out[i] = '0;
    act = 0;
    rd_due = -1;
    idle(2);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    @(posedge clock);
    #1;
    chk_en = 1;
    idle(3);
    rnd_io = 1;
    for (int i = 0; i < 60; i++) begin
      rand_txn();
      idle($urandom_range(0, 2));
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
